jzjpcc_mmio_uart: RTL and testbench
===================================

Name: jzjpcc_mmio_uart

Overview:
8N1 UART peripheral attached to the core's memory-mapped I/O ports. It consumes two mmioOutputs words (TX and control) and produces one mmioInputs status/RX word. Software controls it by whole-word writes and reads. Each command is signalled by flipping a toggle bit, because mmio output registers are level-held rather than strobed.

Parameters:
CLOCKS_PER_BIT, 434, clock cycles per serial bit (must be >= 4).
TX_FIFO_A_WIDTH, 2, TX FIFO depth is 2^TX_FIFO_A_WIDTH bytes.

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
txControl  in  32  from an mmioOutputs word; [7:0] byte to send, [8] push toggle
rxControl  in  32  from an mmioOutputs word; [0] RX ack toggle, [1] clear-errors toggle
uartStatus  out  32  to an mmioInputs word; layout given in Behaviour
uartTx  out  1  serial out, idle high, registered
uartRx  in  1  serial in, asynchronous to clock

Behaviour:
- Reset (reset low, applied asynchronously):
  - uartTx=1.
  - uartStatus=32'h00000400 (only txIdle set).
  - FIFO emptied, both FSMs go to IDLE.
  - Toggle history registers cleared to 0.
  - A frame in progress is abandoned; no partial byte is delivered.
- uartStatus layout:
  - [7:0] rxByte
  - [8] rxValid
  - [9] txFifoFull
  - [10] txIdle (FIFO empty and TX FSM in IDLE)
  - [11] txOverflow (sticky)
  - [12] rxOverrun (sticky)
  - [13] framingError (sticky)
  - [14] parityError (sticky, 0 when parity is compiled out)
  - [15] reserved, reads 0
  - [15+TX_FIFO_A_WIDTH+1:16] FIFO occupancy
  - all higher bits read 0.
  - uartStatus is registered and reflects state one cycle after any event.
- Toggle detection: each toggle bit is compared with a registered copy of its previous value. Any difference is a one-cycle event, so at most one event per toggle per clock.
- TX push event: txControl[7:0] is written into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and txOverflow is set.
  - A push and a pop in the same cycle while full is accepted.
- TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - Leaves IDLE the cycle after the FIFO becomes non-empty, popping the head byte.
  - START drives 0, DATA drives bits LSB first, STOP drives 1.
  - Each bit is held exactly CLOCKS_PER_BIT cycles; the baud counter counts 0..CLOCKS_PER_BIT-1.
  - When STOP ends with the FIFO non-empty, the FSM goes directly to START with no idle gap.
  - Frame length: 10*CLOCKS_PER_BIT cycles.
- RX input conditioning: uartRx passes through a 2-flop synchronizer, reset value 1.
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - In IDLE, a synchronized high-to-low transition enters START.
  - START waits CLOCKS_PER_BIT/2 cycles. If the line is high at that sample, return to IDLE (glitch). Otherwise go to DATA.
  - DATA samples 8 bits at intervals of CLOCKS_PER_BIT, LSB first.
  - STOP sample low: set framingError, discard the byte.
  - STOP sample high: load rxByte, set rxValid.
  - If rxValid was already 1 when a byte loads, set rxOverrun and the new byte overwrites.
- RX ack event: clears rxValid. If a new byte loads in the same cycle, the load wins: rxValid stays 1 and rxOverrun is not set.
- Clear-errors event: clears bits [14:11]. An error raised in the same cycle wins and stays set.

Optional Feature:
JZJPCC_UART_PARITY_EN
- Defined: 8E1 framing. An even-parity bit is inserted between DATA and STOP in both directions, so a frame is 11*CLOCKS_PER_BIT cycles. A parity mismatch on RX sets parityError and discards the byte.
- Undefined: 8N1 framing, no PARITY state in either FSM, and status bit [14] is tied to 0.

Decomposition:
- Package jzjpcc_uart_pkg holds:
  - the TX and RX state enums (including PARITY under the macro);
  - status bit index localparams (RX_VALID_B=8 ... PARITY_ERR_B=14, COUNT_LSB=16);
  - the toggle bit index localparams.
- Sub-module jzjpcc_uart_fifo: synchronous FIFO with parameter A_WIDTH, push/pop/full/empty/count outputs, same clock and reset.

Test Plan:
All scenarios use CLOCKS_PER_BIT=4.
- Reset: hold reset low, then release -> uartTx=1, uartStatus=32'h00000400.
- TX single byte: flip txControl[8] with byte 8'hA5 -> uartTx emits 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each bit 4 cycles, 40 cycles total; txIdle returns to 1.
- TX overflow: 5 push toggles on consecutive cycles while TX is busy -> 4 bytes queued, count=4, txFifoFull=1, txOverflow=1; all 4 frames are sent back to back with no gap.
- RX byte: drive 8'h3C as an 8N1 frame on uartRx -> rxByte=8'h3C and rxValid=1; an ack toggle clears rxValid the next cycle.
- RX errors: a second frame arrives before ack -> rxOverrun=1. A frame with a low stop bit -> framingError=1 and rxByte unchanged. A clear-errors toggle -> [14:11]=0.
- Glitch and mid-frame reset: a 1-cycle low pulse on uartRx -> no byte received. Asserting reset mid-TX -> uartTx=1 immediately, FIFO count=0.

Source files
------------

// File: rtl/jzjpcc_uart_pkg.sv
// Shared types and bit positions for the mmio UART.
// JZJPCC_UART_PARITY_EN adds the PARITY state to both FSMs (8E1 framing).
package jzjpcc_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef JZJPCC_UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef JZJPCC_UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  localparam int unsigned RX_VALID_B   = 8;
  localparam int unsigned TX_FULL_B    = 9;
  localparam int unsigned TX_IDLE_B    = 10;
  localparam int unsigned TX_OVF_B     = 11;
  localparam int unsigned RX_OVR_B     = 12;
  localparam int unsigned FRAME_ERR_B  = 13;
  localparam int unsigned PARITY_ERR_B = 14;
  localparam int unsigned COUNT_LSB    = 16;

  localparam int unsigned TX_PUSH_TOG = 8;
  localparam int unsigned RX_ACK_TOG  = 0;
  localparam int unsigned CLR_ERR_TOG = 1;

endpackage

// File: rtl/jzjpcc_uart_fifo.sv
// Byte FIFO with show-ahead head; push while full is accepted only alongside a pop.
module jzjpcc_uart_fifo #(
  parameter int A_WIDTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic               full,
  output logic               empty,
  output logic [A_WIDTH:0]   count
);

  localparam logic [A_WIDTH:0] DEPTH = (A_WIDTH+1)'(1 << A_WIDTH);

  logic [7:0]         mem_q [2**A_WIDTH];
  logic [A_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [A_WIDTH:0]   cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full  = (cnt_q == DEPTH);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    wr_d    = wr_q + A_WIDTH'(push_ok);
    rd_d    = rd_q + A_WIDTH'(pop_ok);
    cnt_d   = cnt_q + (A_WIDTH+1)'(push_ok) - (A_WIDTH+1)'(pop_ok);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/jzjpcc_mmio_uart.sv
// Toggle-commanded mmio UART: TX FIFO + TX/RX framers. JZJPCC_UART_PARITY_EN selects 8E1.
// state  | meaning
// IDLE   | line idle / waiting (TX: FIFO empty, RX: falling edge)
// START  | start bit (RX: half-bit wait then glitch check)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity builds only)
// STOP   | stop bit
module jzjpcc_mmio_uart
  import jzjpcc_uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int TX_FIFO_A_WIDTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txControl,
  input  logic [31:0] rxControl,
  output logic [31:0] uartStatus,
  output logic        uartTx,
  input  logic        uartRx
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);

  logic tx_tog_q, ack_tog_q, clr_tog_q;
  logic push_evt, ack_evt, clr_evt;
  logic fifo_full, fifo_empty, tx_pop;
  logic [7:0] fifo_head;
  logic [TX_FIFO_A_WIDTH:0] fifo_count;

  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic tx_q, tx_d, tx_end;

  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_end, rx_half, rx_load, rx_ferr;
  logic rx_valid_q, rx_valid_d, ovf_q, ovf_d, ovr_q, ovr_d, fe_q, fe_d;
  logic [31:0] status_q, status_d;
`ifdef JZJPCC_UART_PARITY_EN
  logic tx_par_q, tx_par_d, rx_perr, pe_q, pe_d;
`endif
  logic unused_bits;

  assign unused_bits = ^{txControl[31:9], rxControl[31:2]};
  assign push_evt = txControl[TX_PUSH_TOG] ^ tx_tog_q;
  assign ack_evt  = rxControl[RX_ACK_TOG] ^ ack_tog_q;
  assign clr_evt  = rxControl[CLR_ERR_TOG] ^ clr_tog_q;
  assign tx_end   = (tx_cnt_q == BIT_LAST);
  assign rx_end   = (rx_cnt_q == BIT_LAST);
  assign rx_half  = (rx_cnt_q == HALF_LAST);
  assign uartTx     = tx_q;
  assign uartStatus = status_q;

  jzjpcc_uart_fifo #(.A_WIDTH(TX_FIFO_A_WIDTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_evt),
    .din   (txControl[7:0]),
    .pop   (tx_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_state_q == TX_IDLE || tx_end) ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
`ifdef JZJPCC_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: if (!fifo_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = fifo_head;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
`ifdef JZJPCC_UART_PARITY_EN
        if (tx_bit_q == 3'd7) tx_state_d = TX_PARITY;
      end
      TX_PARITY: if (tx_end) begin
        tx_state_d = TX_STOP;
`else
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
`endif
      end
      TX_STOP: if (tx_end) begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = fifo_head;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
`ifdef JZJPCC_UART_PARITY_EN
    if (tx_pop) tx_par_d = ^fifo_head;
`endif
    // line level follows the state being entered so each bit lasts CLOCKS_PER_BIT cycles
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_sh_d[0];
`ifdef JZJPCC_UART_PARITY_EN
      TX_PARITY: tx_d = tx_par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
`ifdef JZJPCC_UART_PARITY_EN
    rx_perr    = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_half) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
`ifdef JZJPCC_UART_PARITY_EN
        if (rx_bit_q == 3'd7) rx_state_d = RX_PARITY;
      end
      RX_PARITY: if (rx_end) begin
        rx_cnt_d   = '0;
        rx_perr    = ^{rx_sh_q, rx_s2_q};
        rx_state_d = rx_perr ? RX_IDLE : RX_STOP;
`else
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
`endif
      end
      RX_STOP: if (rx_end) begin
        rx_state_d = RX_IDLE;
        rx_load    = rx_s2_q;
        rx_ferr    = ~rx_s2_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_byte_d  = rx_load ? rx_sh_q : rx_byte_q;
    rx_valid_d = rx_load | (rx_valid_q & ~ack_evt);
    ovr_d      = (ovr_q & ~clr_evt) | (rx_load & rx_valid_q & ~ack_evt);
    ovf_d      = (ovf_q & ~clr_evt) | (push_evt & fifo_full & ~tx_pop);
    fe_d       = (fe_q & ~clr_evt) | rx_ferr;
    status_d   = '0;
    status_d[7:0]         = rx_byte_q;
    status_d[RX_VALID_B]  = rx_valid_q;
    status_d[TX_FULL_B]   = fifo_full;
    status_d[TX_IDLE_B]   = fifo_empty && (tx_state_q == TX_IDLE);
    status_d[TX_OVF_B]    = ovf_q;
    status_d[RX_OVR_B]    = ovr_q;
    status_d[FRAME_ERR_B] = fe_q;
`ifdef JZJPCC_UART_PARITY_EN
    pe_d = (pe_q & ~clr_evt) | rx_perr;
    status_d[PARITY_ERR_B] = pe_q;
`endif
    status_d[COUNT_LSB +: TX_FIFO_A_WIDTH+1] = fifo_count;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_tog_q   <= 1'b0;
      ack_tog_q  <= 1'b0;
      clr_tog_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      status_q   <= 32'h0000_0400;
`ifdef JZJPCC_UART_PARITY_EN
      tx_par_q   <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      tx_tog_q   <= txControl[TX_PUSH_TOG];
      ack_tog_q  <= rxControl[RX_ACK_TOG];
      clr_tog_q  <= rxControl[CLR_ERR_TOG];
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_s1_q    <= uartRx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      status_q   <= status_d;
`ifdef JZJPCC_UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      pe_q       <= pe_d;
`endif
    end
  end

endmodule

// File: tb/tb_jzjpcc_mmio_uart.sv
// Directed bench for jzjpcc_mmio_uart in its default 8N1 build, CLOCKS_PER_BIT=4.
module tb_jzjpcc_mmio_uart;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] txControl = '0;
  logic [31:0] rxControl = '0;
  logic [31:0] uartStatus;
  logic        uartTx;
  logic        uartRx = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  jzjpcc_mmio_uart #(.CLOCKS_PER_BIT(4), .TX_FIFO_A_WIDTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .txControl  (txControl),
    .rxControl  (rxControl),
    .uartStatus (uartStatus),
    .uartTx     (uartTx),
    .uartRx     (uartRx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] b);
    txControl = {23'b0, ~txControl[8], b};
    tick(1);
  endtask

  task automatic wait_tx_low(output int lat);
    lat = 0;
    while (uartTx !== 1'b0 && lat < 100) begin
      tick(1);
      lat++;
    end
    if (lat >= 100) check("tx_start_timeout", {31'b0, uartTx}, 32'h0);
  endtask

  // call on the first cycle of a start bit; returns on the cycle after the stop bit
  task automatic cap_frame(output logic [9:0] f);
    for (int k = 0; k < 10; k++) begin
      tick(2);
      f[k] = uartTx;
      tick(2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uartRx = bits[k];
      tick(4);
    end
    uartRx = 1'b1;
  endtask

  initial begin
    int lat;
    int seen_low;
    logic [9:0] f;
    logic [7:0] q_bytes [4];
    q_bytes[0] = 8'h11; q_bytes[1] = 8'h22; q_bytes[2] = 8'h33; q_bytes[3] = 8'h44;

    // reset
    tick(3);
    check("rst_tx", {31'b0, uartTx}, 32'h1);
    check("rst_status", uartStatus, 32'h0000_0400);
    reset = 1'b1;
    tick(3);
    check("post_rst_status", uartStatus, 32'h0000_0400);

    // single byte A5
    push_byte(8'hA5);
    wait_tx_low(lat);
    check("tx_latency", lat, 1);
    cap_frame(f);
    check("tx_frame_a5", {22'b0, f}, {22'b0, 1'b1, 8'hA5, 1'b0});
    tick(2);
    check("tx_idle_line", {31'b0, uartTx}, 32'h1);
    check("tx_idle_status", uartStatus, 32'h0000_0400);

    // overflow: 5 pushes while the first frame is in flight
    push_byte(8'h5A);
    wait_tx_low(lat);
    for (int i = 0; i < 4; i++) push_byte(q_bytes[i]);
    push_byte(8'h55);
    tick(1);
    check("ovf_status", uartStatus, 32'h0004_0A00);
    tick(34);
    for (int i = 0; i < 4; i++) begin
      cap_frame(f);
      check($sformatf("b2b_frame%0d", i), {22'b0, f}, {22'b0, 1'b1, q_bytes[i], 1'b0});
    end
    seen_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (uartTx === 1'b0) seen_low = 1;
    end
    check("no_fifth_frame", seen_low, 0);
    check("ovf_drained", uartStatus, 32'h0000_0C00);

    // RX
    send_frame(8'h3C, 1'b1);
    tick(2);
    check("rx_3c", uartStatus, 32'h0000_0D3C);
    send_frame(8'h81, 1'b1);
    tick(2);
    check("rx_overrun", uartStatus, 32'h0000_1D81);
    rxControl[0] = ~rxControl[0];
    tick(2);
    check("rx_ack", uartStatus, 32'h0000_1C81);
    send_frame(8'hF0, 1'b0);
    tick(2);
    check("rx_framing", uartStatus, 32'h0000_3C81);
    rxControl[1] = ~rxControl[1];
    tick(2);
    check("clr_errors", uartStatus, 32'h0000_0481);

    // glitch
    uartRx = 1'b0;
    tick(1);
    uartRx = 1'b1;
    tick(50);
    check("rx_glitch", uartStatus, 32'h0000_0481);

    // reset in the middle of a TX frame with one byte still queued
    push_byte(8'h77);
    push_byte(8'h66);
    wait_tx_low(lat);
    tick(10);
    reset = 1'b0;
    txControl = '0;
    rxControl = '0;
    #1;
    check("midrst_tx", {31'b0, uartTx}, 32'h1);
    check("midrst_status", uartStatus, 32'h0000_0400);
    tick(3);
    reset = 1'b1;
    seen_low = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (uartTx === 1'b0) seen_low = 1;
    end
    check("midrst_quiet", seen_low, 0);
    check("midrst_after", uartStatus, 32'h0000_0400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
